// File: rtl/lcd_pkg.sv
// lcd_pkg: engine status codes, LCD command bytes, power-on init ROM and FSM states for lcd_ctrl
package lcd_pkg;
  localparam logic [1:0] ST_READY    = 2'b00;
  localparam logic [1:0] ST_TRANSFER = 2'b01;
  localparam logic [1:0] ST_FINISH   = 2'b10;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_FUNC_SET = 8'h30;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam int INIT_LEN = 5;
  typedef enum logic [2:0] {PWR_WAIT, INIT_LOAD, SEND, WAIT_FIN, WAIT_RDY, SETTLE, IDLE} state_e;
  function automatic logic [7:0] init_rom(input logic [2:0] i);
    return i == 3'd0 ? CMD_FUNC_SET :
           i == 3'd1 ? CMD_FUNC_SET :
           i == 3'd2 ? CMD_DISP_ON  :
           i == 3'd3 ? CMD_CLEAR    : CMD_ENTRY;
  endfunction
  // Counter reload value for an N-cycle wait; a zero delay still waits one cycle
  function automatic int dly_ld(input int d);
    return d > 0 ? d - 1 : 0;
  endfunction
endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down-counter that parks at zero and flags it
module lcd_delay_cnt #(
  parameter int CNT_W = 22,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk) cnt_q <= rst ? RST_VAL : cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: byte sequencer for the serial LCD engine with per-byte settle delays.
// Define LCD_CTRL_INIT_EN to build the power-on wait and init ROM sequence.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int PWR_DELAY  = 4000000,
  parameter int CMD_DELAY  = 7200,
  parameter int DATA_DELAY = 7200,
  parameter int CLR_DELAY  = 160000,
  parameter int CNT_W      = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_is_cmd,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_we,
  output logic       lcd_is_cmd,
  output logic [7:0] lcd_data,
  input  logic [1:0] lcd_status
);
  localparam logic [CNT_W-1:0] CMD_LD  = CNT_W'(dly_ld(CMD_DELAY));
  localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(dly_ld(DATA_DELAY));
  localparam logic [CNT_W-1:0] CLR_LD  = CNT_W'(dly_ld(CLR_DELAY));
`ifdef LCD_CTRL_INIT_EN
  localparam state_e           RST_STATE = PWR_WAIT;
  localparam logic             RST_DONE  = 1'b0;
  localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(dly_ld(PWR_DELAY));
  logic [2:0] idx_q, idx_d;
`else
  localparam state_e           RST_STATE = IDLE;
  localparam logic             RST_DONE  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_RST   = '0;
`endif
  state_e state_q, state_d;
  logic is_cmd_q, is_cmd_d;
  logic [7:0] data_q, data_d;
  logic done_q, done_d;
  logic we_q, ready_q, busy_q;
  logic cnt_ld, cnt_zero;
  logic [CNT_W-1:0] settle_ld;
  // The power-on wait runs on the same counter, preloaded while in reset
  lcd_delay_cnt #(.CNT_W(CNT_W), .RST_VAL(CNT_RST)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_ld),
    .load_val (settle_ld),
    .zero     (cnt_zero)
  );
  always_comb settle_ld = !is_cmd_q ? DATA_LD :
                          (data_q == CMD_CLEAR || data_q == CMD_HOME) ? CLR_LD : CMD_LD;
  always_comb begin
    state_d  = state_q;
    is_cmd_d = is_cmd_q;
    data_d   = data_q;
    done_d   = done_q;
    cnt_ld   = 1'b0;
`ifdef LCD_CTRL_INIT_EN
    idx_d    = idx_q;
`endif
    case (state_q)
`ifdef LCD_CTRL_INIT_EN
      PWR_WAIT: if (cnt_zero) state_d = INIT_LOAD;
      INIT_LOAD: begin
        is_cmd_d = 1'b1;
        data_d   = init_rom(idx_q);
        idx_d    = idx_q + 3'd1;
        state_d  = SEND;
      end
`endif
      IDLE: if (req_valid) begin
        is_cmd_d = req_is_cmd;
        data_d   = req_data;
        state_d  = SEND;
      end
      // Never write into an engine that is still busy or reporting an illegal code
      SEND:     if (lcd_status == ST_READY) state_d = WAIT_FIN;
      WAIT_FIN: if (lcd_status == ST_FINISH) state_d = WAIT_RDY;
      WAIT_RDY: if (lcd_status == ST_READY) begin
        cnt_ld  = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: if (cnt_zero) begin
`ifdef LCD_CTRL_INIT_EN
        done_d  = done_q | (idx_q == 3'(INIT_LEN));
        state_d = done_d ? IDLE : INIT_LOAD;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      is_cmd_q <= 1'b0;
      data_q   <= '0;
      done_q   <= RST_DONE;
      we_q     <= 1'b0;
      ready_q  <= RST_STATE == IDLE;
      busy_q   <= RST_STATE != IDLE;
    end else begin
      state_q  <= state_d;
      is_cmd_q <= is_cmd_d;
      data_q   <= data_d;
      done_q   <= done_d;
      we_q     <= state_d == WAIT_FIN;
      ready_q  <= state_d == IDLE;
      busy_q   <= state_d != IDLE;
    end
  end
`ifdef LCD_CTRL_INIT_EN
  always_ff @(posedge clk) idx_q <= rst ? 3'd0 : idx_d;
`endif
  assign req_ready  = ready_q;
  assign init_done  = done_q;
  assign busy       = busy_q;
  assign lcd_we     = we_q;
  assign lcd_is_cmd = is_cmd_q;
  assign lcd_data   = data_q;
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scoreboard bench for lcd_ctrl with a simple transfer-engine model
module tb_lcd_ctrl;
  import lcd_pkg::*;
  localparam int PWR = 20, CMD = 5, DAT = 7, CLR = 12;
`ifdef LCD_CTRL_INIT_EN
  localparam bit INIT = 1'b1;
`else
  localparam bit INIT = 1'b0;
`endif
  typedef struct {logic is_cmd; logic [7:0] data; int gap;} exp_t;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_is_cmd = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic req_ready, init_done, busy, lcd_we, lcd_is_cmd;
  logic [7:0] lcd_data;
  logic [1:0] lcd_status;
  logic [1:0] eng = ST_READY, ovr_val = ST_READY;
  logic ovr = 1'b0;
  int eng_cnt = 0;
  int n_cmp = 0, n_bad = 0;
  exp_t q[$];
  exp_t cur;
  bit mon_en = 1'b0, active = 1'b0;
  logic prev_we = 1'b0;
  int low = 0;
  logic [7:0] seq_b [5] = '{8'h30, 8'h30, 8'h0C, 8'h01, 8'h06};
  int seq_g [5] = '{CMD, CMD, CMD, CLR, CMD};

  always #5 clk = ~clk;

  lcd_ctrl #(.PWR_DELAY(PWR), .CMD_DELAY(CMD), .DATA_DELAY(DAT), .CLR_DELAY(CLR), .CNT_W(22)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_cmd(req_is_cmd), .req_data(req_data),
    .req_ready(req_ready), .init_done(init_done), .busy(busy), .lcd_we(lcd_we),
    .lcd_is_cmd(lcd_is_cmd), .lcd_data(lcd_data), .lcd_status(lcd_status)
  );

  // Engine: takes a write, transfers for 4 cycles, holds FINISH until the write drops
  assign lcd_status = ovr ? ovr_val : eng;
  always @(posedge clk) begin
    if (eng == ST_READY && lcd_we) begin eng <= ST_TRANSFER; eng_cnt <= 3; end
    else if (eng == ST_TRANSFER) begin
      if (eng_cnt == 0) eng <= ST_FINISH; else eng_cnt <= eng_cnt - 1;
    end else if (eng == ST_FINISH && !lcd_we) eng <= ST_READY;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each new write pops the scoreboard, then data hold and settle gap are checked
  always @(negedge clk) begin
    if (!mon_en) begin
      active = 1'b0;
      prev_we = 1'b0;
    end else begin
      chk("ready_only_idle", req_ready, !busy);
      if (lcd_we && !prev_we) begin
        if (active) chk("init_gap", low, cur.gap + 4);
        active = 1'b0;
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got %0h expected none at %0t", {lcd_is_cmd, lcd_data}, $time);
        end else begin
          cur = q.pop_front();
          chk("byte", {lcd_is_cmd, lcd_data}, {cur.is_cmd, cur.data});
          active = 1'b1;
          low = 0;
        end
      end else if (active) begin
        if (!lcd_we && !busy) begin
          chk("settle_gap", low, cur.gap + 2);
          active = 1'b0;
        end else begin
          if (!lcd_we) low++;
          if (low <= cur.gap + 2) chk("hold", {lcd_is_cmd, lcd_data}, {cur.is_cmd, cur.data});
        end
      end
      prev_we = lcd_we;
    end
  end

  task automatic push_init();
    for (int i = 0; i < 5; i++) q.push_back('{1'b1, seq_b[i], seq_g[i]});
  endtask

  task automatic send(input logic c, input logic [7:0] d, input int g, input bit chk_we, input bit keep);
    int t = 0;
    q.push_back('{c, d, g});
    req_valid = 1'b1; req_is_cmd = c; req_data = d;
    while (!req_ready && t < 500) begin @(negedge clk); t++; end
    chk("accept_wait", req_ready, 1);
    @(posedge clk); #1;
    chk("ready_fall", req_ready, 0);
    if (!keep) req_valid = 1'b0;
    if (chk_we) begin
      @(posedge clk); #1;
      chk("we_latency", {lcd_we, lcd_is_cmd, lcd_data}, {1'b1, c, d});
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 500) begin @(negedge clk); t++; end
    chk(name, busy, 0);
  endtask

  task automatic wait_init();
    int t = 0;
    while (!init_done && t < 1000) begin @(negedge clk); t++; end
    chk("init_done", init_done, 1);
    chk("init_idle", {busy, req_ready}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we_data", {lcd_we, lcd_is_cmd, lcd_data}, 10'h000);
    chk("rst_ready", req_ready, !INIT);
    chk("rst_init_done", init_done, !INIT);
    chk("rst_busy", busy, INIT);
    if (INIT) push_init();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    if (INIT) begin
      t = 0;
      do begin
        @(negedge clk);
        if (!lcd_we) t++;
      end while (!lcd_we && t < 200);
      chk("pwr_wait", t, PWR + 1);
      wait_init();
    end
    send(1'b0, 8'h41, DAT, 1'b1, 1'b0);
    wait_idle("data_idle");
    send(1'b1, 8'h01, CLR, 1'b1, 1'b1);
    send(1'b0, 8'h42, DAT, 1'b1, 1'b0);
    wait_idle("b2b_idle");
    ovr_val = ST_TRANSFER;
    ovr = 1'b1;
    send(1'b1, 8'h02, CLR, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("we_held_low", lcd_we, 0);
    end
    ovr = 1'b0;
    t = 0;
    while (!lcd_we && t < 5) begin @(negedge clk); t++; end
    chk("we_after_ready", lcd_we, 1);
    wait_idle("notrdy_idle");
    send(1'b0, 8'h55, DAT, 1'b1, 1'b0);
    ovr_val = 2'b11;
    ovr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("we_on_illegal", lcd_we, 1);
    end
    ovr = 1'b0;
    t = 0;
    while (lcd_we && t < 5) begin @(negedge clk); t++; end
    chk("we_drop_on_finish", lcd_we, 0);
    wait_idle("illegal_idle");
    send(1'b1, 8'h80, CMD, 1'b1, 1'b0);
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_we", lcd_we, 0);
    chk("rst_mid_init_done", init_done, !INIT);
    chk("rst_mid_busy", busy, INIT);
    rst = 1'b0;
    q.delete();
    if (INIT) push_init();
    mon_en = 1'b1;
    if (INIT) wait_init();
    else begin
      repeat (10) @(negedge clk);
      send(1'b0, 8'h43, DAT, 1'b1, 1'b0);
      wait_idle("post_rst_idle");
    end
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
